// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer owning the HI/LO pair.
// One shift-add or restore-subtract step per clock; stalls the pipeline while busy.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT              stateQ, stateD;
  logic [CW-1:0]      countQ, countD;
  logic [2*WIDTH-1:0] prodQ, prodD;
  logic [WIDTH-1:0]   remQ, remD;
  logic [WIDTH-1:0]   quotQ, quotD;
  logic [WIDTH-1:0]   operandQ, operandD;
  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divDiff;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quotNext;
  logic               accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      countQ   <= '0;
      prodQ    <= '0;
      remQ     <= '0;
      quotQ    <= '0;
      operandQ <= '0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      stateQ   <= stateD;
      countQ   <= countD;
      prodQ    <= prodD;
      remQ     <= remD;
      quotQ    <= quotD;
      operandQ <= operandD;
      hiQ      <= hiD;
      loQ      <= loD;
    end
  end

  // operandQ holds the multiplicand during MUL and the divisor during DIV
  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    prodD    = prodQ;
    remD     = remQ;
    quotD    = quotQ;
    operandD = operandQ;
    hiD      = hiQ;
    loD      = loQ;

    mulSum   = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + {1'b0, (prodQ[0] ? operandQ : {WIDTH{1'b0}})};
    mulNext  = {mulSum, prodQ[WIDTH-1:1]};

    divShift = {remQ, quotQ[WIDTH-1]};
    divGe    = (divShift >= {1'b0, operandQ});
    divDiff  = divShift[WIDTH-1:0] - operandQ;
    remNext  = divGe ? divDiff : divShift[WIDTH-1:0];
    quotNext = {quotQ[WIDTH-2:0], divGe};

    accept   = start && !flush && ((stateQ == IDLE) || (stateQ == DONE));

    case (stateQ)
      MUL: begin
        prodD  = mulNext;
        countD = countQ + CW'(1);
        if (countQ == LAST) begin
          hiD    = mulNext[2*WIDTH-1:WIDTH];
          loD    = mulNext[WIDTH-1:0];
          countD = '0;
          stateD = DONE;
        end
      end
      DIV: begin
        remD   = remNext;
        quotD  = quotNext;
        countD = countQ + CW'(1);
        if (countQ == LAST) begin
          hiD    = remNext;
          loD    = quotNext;
          countD = '0;
          stateD = DONE;
        end
      end
      default: begin
        stateD = IDLE;
        if (accept) begin
          case (funct)
            FUNCT_MULTU: begin
              stateD   = MUL;
              countD   = '0;
              prodD    = {{WIDTH{1'b0}}, op_b};
              operandD = op_a;
            end
            FUNCT_DIVU: begin
              // Divide-by-zero completes immediately with the conventional all-ones quotient
              if (op_b == '0) begin
                stateD = DONE;
                loD    = '1;
                hiD    = op_a;
              end else begin
                stateD   = DIV;
                countD   = '0;
                remD     = '0;
                quotD    = op_a;
                operandD = op_b;
              end
            end
            FUNCT_MTHI: hiD = op_a;
            FUNCT_MTLO: loD = op_a;
            default: ;
          endcase
        end
      end
    endcase

    if (flush) begin
      stateD = IDLE;
      countD = '0;
      hiD    = hiQ;
      loD    = loQ;
    end
  end

  assign busy  = (stateQ == MUL) || (stateQ == DIV);
  assign done  = (stateQ == DONE);
  assign stall = busy && (rd_req || start);
  assign hi    = hiQ;
  assign lo    = loQ;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a countdown/arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed HI/LO values.
module tb_muldiv_seq;

  localparam int W = 32;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic         clk;
  logic         rstN;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         rdReq;
  logic         flush;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  int           mLeft = 0;
  bit           mDone = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  logic [W-1:0] pendHi = '0;
  logic [W-1:0] pendLo = '0;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] h;
    logic [W-1:0] l;
  } vecT;
  vecT tbl[6];

  muldiv_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rstN),
    .start  (start),
    .funct  (funct),
    .op_a   (opA),
    .op_b   (opB),
    .rd_req (rdReq),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: an accepted MULTU/DIVU is busy for W edges, then HI/LO take the arithmetic result
  always @(posedge clk) begin
    logic [2*W-1:0] p;
    if (!rstN) begin
      mLeft = 0;
      mDone = 0;
      mHi   = '0;
      mLo   = '0;
    end else begin
      mDone = 0;
      if (flush) begin
        mLeft = 0;
      end else if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mHi   = pendHi;
          mLo   = pendLo;
          mDone = 1;
        end
      end else if (start) begin
        case (funct)
          MULTU: begin
            p      = {{W{1'b0}}, opA} * {{W{1'b0}}, opB};
            pendHi = p[2*W-1:W];
            pendLo = p[W-1:0];
            mLeft  = W;
          end
          DIVU: begin
            if (opB == 0) begin
              mHi   = opA;
              mLo   = '1;
              mDone = 1;
            end else begin
              pendLo = opA / opB;
              pendHi = opA % opB;
              mLeft  = W;
            end
          end
          MTHI: mHi = opA;
          MTLO: mLo = opA;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_busy", W'(busy), W'(mLeft > 0));
      checkOutput("cyc_done", W'(done), W'(mDone));
      checkOutput("cyc_stall", W'(stall), W'((mLeft > 0) && (rdReq || start)));
      checkOutput("cyc_hi", hi, mHi);
      checkOutput("cyc_lo", lo, mLo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = s;
    funct = f;
    opA   = a;
    opB   = b;
  endtask

  task automatic runOp(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    applyStimulus(1, f, a, b);
    tick();
    applyStimulus(0, 6'd0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{MULTU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000};
    tbl[1] = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    tbl[2] = '{DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF};
    tbl[3] = '{DIVU,  32'h0000_0007, 32'h0000_0009, 32'h0000_0007, 32'h0000_0000};
    tbl[4] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[5] = '{DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    rstN = 0; rdReq = 0; flush = 0;
    applyStimulus(0, 6'd0, '0, '0);
    tick();
    tick();
    rstN = 1;
    checking = 1;
    @(negedge clk);
    checkOutput("reset_busy", W'(busy), 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);

    $display("[TB] MULTU 7*6");
    runOp(MULTU, 7, 6);
    @(negedge clk);
    checkOutput("t1_busy_first", W'(busy), 1);
    repeat (31) tick();
    @(negedge clk);
    checkOutput("t1_busy_last", W'(busy), 1);
    checkOutput("t1_lo_while_busy", lo, 0);
    tick();
    @(negedge clk);
    checkOutput("t1_done", W'(done), 1);
    checkOutput("t1_hi", hi, 0);
    checkOutput("t1_lo", lo, 42);
    checkOutput("t1_stall", W'(stall), 0);
    tick();
    @(negedge clk);
    checkOutput("t1_done_cleared", W'(done), 0);

    $display("[TB] MULTU max*max then back-to-back DIVU 100/7");
    applyStimulus(1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1, DIVU, 100, 7);
    @(negedge clk);
    checkOutput("t2_stall_on_start", W'(stall), 1);
    repeat (32) tick();
    @(negedge clk);
    checkOutput("t2_mul_done", W'(done), 1);
    checkOutput("t2_mul_hi", hi, 32'hFFFF_FFFE);
    checkOutput("t2_mul_lo", lo, 32'h0000_0001);
    tick();
    applyStimulus(0, 6'd0, '0, '0);
    @(negedge clk);
    checkOutput("t2_div_busy", W'(busy), 1);
    repeat (32) tick();
    @(negedge clk);
    checkOutput("t2_div_done", W'(done), 1);
    checkOutput("t2_div_lo", lo, 14);
    checkOutput("t2_div_hi", hi, 2);
    tick();

    $display("[TB] DIVU by zero, MTHI");
    runOp(DIVU, 5, 0);
    @(negedge clk);
    checkOutput("t3_done", W'(done), 1);
    checkOutput("t3_busy", W'(busy), 0);
    checkOutput("t3_lo", lo, 32'hFFFF_FFFF);
    checkOutput("t3_hi", hi, 5);
    tick();
    runOp(MTHI, 32'h0000_ABCD, 0);
    @(negedge clk);
    checkOutput("t3_mthi_hi", hi, 32'h0000_ABCD);
    checkOutput("t3_mthi_done", W'(done), 0);
    checkOutput("t3_mthi_lo", lo, 32'hFFFF_FFFF);

    $display("[TB] rd_req stall during MULTU");
    runOp(MULTU, 12345, 678);
    repeat (2) tick();
    rdReq = 1;
    @(negedge clk);
    checkOutput("t4_stall_first", W'(stall), 1);
    repeat (29) tick();
    @(negedge clk);
    checkOutput("t4_stall_last", W'(stall), 1);
    tick();
    @(negedge clk);
    checkOutput("t4_stall_released", W'(stall), 0);
    checkOutput("t4_hi", hi, 0);
    checkOutput("t4_lo", lo, 8369910);
    rdReq = 0;
    tick();

    $display("[TB] flush mid DIVU");
    runOp(MTHI, 1, 0);
    runOp(MTLO, 2, 0);
    runOp(DIVU, 1000, 3);
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    checkOutput("t5_busy", W'(busy), 0);
    checkOutput("t5_hi", hi, 1);
    checkOutput("t5_lo", lo, 2);
    repeat (40) tick();
    @(negedge clk);
    checkOutput("t5_no_late_done", W'(done), 0);
    checkOutput("t5_lo_later", lo, 2);

    $display("[TB] reset mid MULTU");
    runOp(MULTU, 1000, 1000);
    repeat (4) tick();
    rstN = 0;
    rdReq = 1;
    tick();
    rstN = 1;
    @(negedge clk);
    checkOutput("t6_hi", hi, 0);
    checkOutput("t6_lo", lo, 0);
    checkOutput("t6_busy", W'(busy), 0);
    checkOutput("t6_done", W'(done), 0);
    checkOutput("t6_stall", W'(stall), 0);
    rdReq = 0;
    runOp(MULTU, 3, 3);
    repeat (32) tick();
    @(negedge clk);
    checkOutput("t6_fresh_done", W'(done), 1);
    checkOutput("t6_fresh_lo", lo, 9);
    tick();

    $display("[TB] start dropped under flush, unknown funct, flush in DONE");
    flush = 1;
    applyStimulus(1, MTLO, 55, 0);
    tick();
    applyStimulus(0, 6'd0, '0, '0);
    flush = 0;
    @(negedge clk);
    checkOutput("t7_mtlo_dropped", lo, 9);
    runOp(6'b100000, 77, 0);
    @(negedge clk);
    checkOutput("t7_unknown_busy", W'(busy), 0);
    checkOutput("t7_unknown_hi", hi, 0);
    runOp(MULTU, 5, 5);
    repeat (32) tick();
    flush = 1;
    applyStimulus(1, MULTU, 2, 2);
    tick();
    flush = 0;
    applyStimulus(0, 6'd0, '0, '0);
    @(negedge clk);
    checkOutput("t7_flush_done_busy", W'(busy), 0);
    checkOutput("t7_flush_done_lo", lo, 25);

    $display("[TB] operand boundary table");
    foreach (tbl[i]) begin
      runOp(tbl[i].f, tbl[i].a, tbl[i].b);
      repeat (32) tick();
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_done", i), W'(done), 1);
      checkOutput($sformatf("tbl%0d_hi", i), hi, tbl[i].h);
      checkOutput($sformatf("tbl%0d_lo", i), lo, tbl[i].l);
      tick();
    end

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
